// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg -- shared definitions for the shift-and-add multiplier.
//   MULT_W   : operand width (8)
//   PROD_W   : product / accumulator width (2*MULT_W)
//   CNT_W    : bit-iteration counter width
//   state_e  : controller state codes (also exported on the pss debug port)
//   mplr_exhausted() : true when the multiplier has no set bits left after
//                      the pending right shift (used by early termination)
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_W = 8;
    localparam int PROD_W = 2 * MULT_W;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    // The bit shifted out this cycle has already been added, so only the
    // upper bits decide whether any partial product remains.
    function automatic logic mplr_exhausted(input logic [MULT_W-1:0] m);
        return (m[MULT_W-1:1] == {(MULT_W-1){1'b0}});
    endfunction

endpackage

// File: rtl/mult_ctrl.sv
// ---------------------------------------------------------------------------
// mult_ctrl -- sequencing FSM for the shift-and-add multiplier.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : request; only honoured in IDLE
//   shift_last  : datapath says the SHIFT in progress is the final one
//   ld          : load operands / clear accumulator and counter
//   add_en      : conditionally add multiplicand into accumulator
//   sh_en       : shift multiplicand left, multiplier right
//   cnt_en      : advance bit counter
//   done        : one-cycle completion pulse (DONE state)
//   busy        : any state other than IDLE
//   state       : current state code
// ---------------------------------------------------------------------------
module mult_ctrl
    import mult_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   shift_last,
    output logic   ld,
    output logic   add_en,
    output logic   sh_en,
    output logic   cnt_en,
    output logic   done,
    output logic   busy,
    output state_e state
);

    state_e state_r;
    state_e state_next_s;

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and strobe decode; all strobes are pure decodes of state_r.
    always_comb begin
        state_next_s = state_r;
        ld           = 1'b0;
        add_en       = 1'b0;
        sh_en        = 1'b0;
        cnt_en       = 1'b0;
        done         = 1'b0;
        busy         = 1'b1;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                ld           = 1'b1;
                state_next_s = ADD;
            end
            ADD: begin
                add_en       = 1'b1;
                state_next_s = SHIFT;
            end
            SHIFT: begin
                sh_en  = 1'b1;
                cnt_en = 1'b1;
                if (shift_last) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ADD;
                end
            end
            DONE: begin
                done         = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                // Unused codes 5-7 recover to IDLE.
                busy         = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    assign state = state_r;

endmodule

// File: rtl/shift_add_mult.sv
// ---------------------------------------------------------------------------
// shift_add_mult -- 8x8 unsigned sequential shift-and-add multiplier.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (aborts any operation)
//   start   : request a multiplication (sampled only in IDLE)
//   a, b    : multiplicand / multiplier, captured in the LOAD cycle
//   product : accumulator; valid with done, held until the next LOAD
//   done    : one-cycle completion pulse
//   busy    : high in every state except IDLE
//   pss     : current controller state code (debug)
// Build option:
//   SHIFT_ADD_MULT_EARLY_TERM_EN -- when defined, finish as soon as the
//   multiplier has no set bits left; products are identical either way.
// ---------------------------------------------------------------------------
module shift_add_mult
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    output logic [PROD_W-1:0] product,
    output logic              done,
    output logic              busy,
    output logic [2:0]        pss
);

    logic [PROD_W-1:0] mcand_r;
    logic [MULT_W-1:0] mplr_r;
    logic [PROD_W-1:0] acc_r;
    logic [CNT_W-1:0]  cnt_r;

    logic   ld_s;
    logic   add_en_s;
    logic   sh_en_s;
    logic   cnt_en_s;
    logic   shift_last_s;
    state_e state_s;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    assign shift_last_s = (cnt_r == 3'd7) || mplr_exhausted(mplr_r);
`else
    assign shift_last_s = (cnt_r == 3'd7);
`endif

    mult_ctrl u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .shift_last (shift_last_s),
        .ld         (ld_s),
        .add_en     (add_en_s),
        .sh_en      (sh_en_s),
        .cnt_en     (cnt_en_s),
        .done       (done),
        .busy       (busy),
        .state      (state_s)
    );

    // Datapath registers driven by the controller strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r <= {PROD_W{1'b0}};
            mplr_r  <= {MULT_W{1'b0}};
            acc_r   <= {PROD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (ld_s) begin
            mcand_r <= {{MULT_W{1'b0}}, a};
            mplr_r  <= b;
            acc_r   <= {PROD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            // 8x8 product fits in 16 bits, so the sum never overflows.
            if (add_en_s && mplr_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            if (sh_en_s) begin
                mcand_r <= mcand_r << 1;
                mplr_r  <= mplr_r >> 1;
            end
            if (cnt_en_s) begin
                cnt_r <= cnt_r + 3'd1;
            end
        end
    end

    assign product = acc_r;
    assign pss     = state_s;

endmodule

// File: tb/tb_shift_add_mult.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mult -- directed self-checking bench for shift_add_mult.
// Cycle numbering: cycle 1 is the LOAD cycle that follows the edge which
// samples start; done is expected in cycle 18 (or earlier when built with
// SHIFT_ADD_MULT_EARLY_TERM_EN).
// ---------------------------------------------------------------------------
module tb_shift_add_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        done;
    logic        busy;
    logic [2:0]  pss;

    int vectors;
    int miscompares;

    shift_add_mult dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .done    (done),
        .busy    (busy),
        .pss     (pss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until done is seen, with a cycle budget; cyc tracks the cycle number.
    task automatic wait_done(inout int cyc);
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Expected cycle in which done appears for multiplier bv.
    function automatic int exp_lat(input logic [7:0] bv);
        int l;
        l = 18;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        l = 4;
        for (int i = 0; i < 8; i++) begin
            if (bv[i]) l = 2 + 2 * (i + 1);
        end
`endif
        return l;
    endfunction

    // Pulse start for one sampling edge; afterwards we sit in cycle 1 (LOAD).
    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int done_seen;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_product", product, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pss", pss, 0);

        // 13 x 11 = 143
        launch(8'd13, 8'd11);
        cyc = 1;
        chk("t1_pss_load", pss, 1);
        chk("t1_busy", busy, 1);
        tick();
        cyc++;
        chk("t1_acc_cleared", product, 0);
        wait_done(cyc);
        chk("t1_latency", cyc, exp_lat(8'd11));
        chk("t1_product", product, 143);
        chk("t1_pss_done", pss, 4);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_product_hold", product, 143);

        // 255 x 255 = 65025, full latency in both builds
        launch(8'd255, 8'd255);
        cyc = 1;
        wait_done(cyc);
        chk("t2_latency", cyc, 18);
        chk("t2_product", product, 65025);
        tick();

        // 200 x 0 = 0
        launch(8'd200, 8'd0);
        cyc = 1;
        wait_done(cyc);
        chk("t3_latency", cyc, exp_lat(8'd0));
        chk("t3_product", product, 0);
        tick();

        // 7 x 3 with start re-pulsed (a=9, b=9) during cycle 5: ignored
        launch(8'd7, 8'd3);
        cyc = 1;
        while (cyc < 5) begin
            tick();
            cyc++;
        end
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        tick();
        cyc++;
        start = 1'b0;
        wait_done(cyc);
        chk("t4_latency", cyc, exp_lat(8'd3));
        chk("t4_product", product, 21);
        tick();
        tick();
        chk("t4_no_restart", busy, 0);

        // 50 x 50 aborted by reset in cycle 9
        launch(8'd50, 8'd50);
        cyc = 1;
        while (cyc < 9) begin
            tick();
            cyc++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_pss_idle", pss, 0);
        chk("t5_busy", busy, 0);
        chk("t5_product", product, 0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        chk("t5_no_done", done_seen, 0);

        // Reset has priority over start
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("t5_rst_prio", pss, 0);

        // Fresh start after abort
        launch(8'd50, 8'd50);
        cyc = 1;
        wait_done(cyc);
        chk("t5_latency", cyc, exp_lat(8'd50));
        chk("t5_product2", product, 2500);
        tick();

        // start held high: back-to-back 3 x 5
        a     = 8'd3;
        b     = 8'd5;
        start = 1'b1;
        tick();
        cyc = 1;
        wait_done(cyc);
        chk("t6a_latency", cyc, exp_lat(8'd5));
        chk("t6a_product", product, 15);
        tick();
        chk("t6a_done_pulse", done, 0);
        chk("t6a_pss_idle", pss, 0);
        tick();
        chk("t6b_pss_load", pss, 1);
        cyc = 1;
        wait_done(cyc);
        chk("t6b_latency", cyc, exp_lat(8'd5));
        chk("t6b_product", product, 15);
        start = 1'b0;
        tick();
        chk("t6b_done_pulse", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a multiplication; sampled only in IDLE.
REQ-004 SHALL have port a, input, 8 bits: unsigned multiplicand, sampled in the LOAD cycle.
REQ-005 SHALL have port b, input, 8 bits: unsigned multiplier, sampled in the LOAD cycle.
REQ-006 SHALL have port product, output, 16 bits: accumulator value; valid while done=1 and held until the next LOAD.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid product.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port pss, output, 3 bits: current state code, for debug.

Function
REQ-010 SHALL implement FSM states IDLE=0, LOAD=1, ADD=2, SHIFT=3, DONE=4; codes 5-7 SHALL go to IDLE.
REQ-011 SHALL handle IDLE: start=1 -> LOAD, else stay in IDLE.
REQ-012 SHALL handle LOAD: mcand(16b) <= {8'h00,a}; mplr(8b) <= b; acc <= 0; cnt(3b) <= 0; -> ADD.
REQ-013 SHALL handle ADD: if mplr[0]=1 then acc <= acc + mcand, truncated to 16 bits (no overflow is possible); -> SHIFT.
REQ-014 SHALL handle SHIFT: mcand <= mcand<<1; mplr <= mplr>>1; cnt <= cnt+1; cnt==7 -> DONE, else -> ADD.
REQ-015 SHALL handle DONE: done=1 for exactly this cycle; -> IDLE.
REQ-016 SHALL assert done for the first time 18 cycles after the edge that samples start (1 LOAD + 8x(ADD+SHIFT) + DONE), with no early termination.
REQ-017 SHALL ignore start while busy=1; a start held high through DONE SHALL launch the next operation from IDLE.
REQ-018 SHALL take product directly from acc, so product reads 0 from the cycle after LOAD.
REQ-019 SHALL give a=0 or b=0 product=0 with unchanged latency when early termination is compiled out.

Reset
REQ-020 SHALL, when rst=1 at a clock edge, force state IDLE, acc=0, mcand=0, mplr=0, cnt=0, so that product=0, done=0 and busy=0.
REQ-021 SHALL abort any operation in progress on rst mid-operation, with no done pulse; rst SHALL take priority over start.

Configuration
REQ-022 SHALL use macro SHIFT_ADD_MULT_EARLY_TERM_EN.
REQ-023 SHALL, with the macro defined, leave SHIFT for DONE when the shifted mplr==0 or cnt==7, so latency = 2 + 2*(index of highest set bit of b, +1), minimum 4.
REQ-024 SHALL, without the macro, have a fixed latency of 18 cycles; product values SHALL be identical in both builds.

Structure
REQ-025 SHALL place the state codes and constant MULT_W=8 in the shared package mult_pkg.
REQ-026 SHALL split into a controller sub-module mult_ctrl (FSM, control strobes ld, add_en, sh_en, cnt_en, done) and a datapath in shift_add_mult.

Verification
REQ-027 SHALL cover: a=13, b=11, start pulse -> done at cycle 18, product=143 (16'h008F).
REQ-028 SHALL cover: a=255, b=255 -> product=65025 (16'hFE01); with early termination, done still at cycle 18.
REQ-029 SHALL cover: a=200, b=0 -> product=0; done at cycle 4 with the macro, cycle 18 without.
REQ-030 SHALL cover: a=7, b=3, then start re-pulsed with a=9, b=9 at cycle 5 -> second start ignored; product=21.
REQ-031 SHALL cover: a=50, b=50, rst high at cycle 9 -> state IDLE, busy=0, product=0, no done; a new start then gives 2500.
REQ-032 SHALL cover: start held high continuously with a=3, b=5 -> back-to-back operations, each giving product=15 and a one-cycle done.
